// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port synchronous data RAM.
// Serialises requests, waits out the RAM read latency and returns data with a one-cycle ack.
module dmem_arbiter #(
   parameter int RD_LATENCY = 1,
   parameter int RR_MODE    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic [3:0]  m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_ack,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic [3:0]  m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_ack,
   output logic [31:0] m1_rdata,
   output logic        ram_en,
   output logic [3:0]  ram_we,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   output logic        busy,
   output logic        grant_id
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t      state;
   logic [1:0]  cnt;
   logic        prio;      // port favoured on the next tie
   logic        is_read;
   logic        win;
   logic [3:0]  sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;

   always_comb begin
      win = 1'b0;
      if (m0_req && m1_req)
         win = (RR_MODE != 0) ? prio : 1'b0;
      else if (m1_req)
         win = 1'b1;
      sel_we    = win ? m1_we    : m0_we;
      sel_addr  = win ? m1_addr  : m0_addr;
      sel_wdata = win ? m1_wdata : m0_wdata;
   end

   assign busy = (state != IDLE);

   // WAIT lasts RD_LATENCY cycles; data is captured on the edge that enters RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 2'd0;
         prio      <= 1'b0;
         is_read   <= 1'b0;
         grant_id  <= 1'b0;
         ram_en    <= 1'b0;
         ram_we    <= 4'd0;
         ram_addr  <= 32'd0;
         ram_wdata <= 32'd0;
         m0_ack    <= 1'b0;
         m1_ack    <= 1'b0;
         m0_rdata  <= 32'd0;
         m1_rdata  <= 32'd0;
      end else begin
         m0_ack <= 1'b0;
         m1_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (m0_req || m1_req) begin
                  grant_id  <= win;
                  prio      <= ~win;
                  ram_en    <= 1'b1;
                  ram_we    <= sel_we;
                  ram_addr  <= sel_addr & ~32'h3;
                  ram_wdata <= sel_wdata;
                  is_read   <= (sel_we == 4'd0);
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               ram_en <= 1'b0;
               ram_we <= 4'd0;
               cnt    <= 2'(RD_LATENCY - 1);
               state  <= WAIT;
            end
            WAIT: begin
               if (cnt == 2'd0) begin
                  if (is_read) begin
                     if (grant_id) m1_rdata <= ram_rdata;
                     else          m0_rdata <= ram_rdata;
                  end
                  if (grant_id) m1_ack <= 1'b1;
                  else          m0_ack <= 1'b1;
                  state <= RESP;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (L=1 RR, L=1 fixed, L=3 RR) each with a RAM model.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req   [3][2];
   logic [3:0]  we    [3][2];
   logic [31:0] addr  [3][2];
   logic [31:0] wdata [3][2];
   logic        ack   [3][2];
   logic [31:0] rdata [3][2];
   logic        ram_en    [3];
   logic [3:0]  ram_we    [3];
   logic [31:0] ram_addr  [3];
   logic [31:0] ram_wdata [3];
   logic [31:0] ram_rdata [3];
   logic        busy      [3];
   logic        grant_id  [3];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int L  = (gi == 2) ? 3 : 1;
      localparam int RR = (gi == 1) ? 0 : 1;
      logic [31:0] mem  [64];
      logic [31:0] pipe [L];

      dmem_arbiter #(.RD_LATENCY(L), .RR_MODE(RR)) u_dut (
         .clk(clk), .rst(rst),
         .m0_req(req[gi][0]), .m0_we(we[gi][0]), .m0_addr(addr[gi][0]), .m0_wdata(wdata[gi][0]),
         .m0_ack(ack[gi][0]), .m0_rdata(rdata[gi][0]),
         .m1_req(req[gi][1]), .m1_we(we[gi][1]), .m1_addr(addr[gi][1]), .m1_wdata(wdata[gi][1]),
         .m1_ack(ack[gi][1]), .m1_rdata(rdata[gi][1]),
         .ram_en(ram_en[gi]), .ram_we(ram_we[gi]), .ram_addr(ram_addr[gi]),
         .ram_wdata(ram_wdata[gi]), .ram_rdata(ram_rdata[gi]),
         .busy(busy[gi]), .grant_id(grant_id[gi])
      );

      // Read data is only present on the bus exactly L cycles after ram_en.
      always @(posedge clk) begin
         if (ram_en[gi])
            for (int b = 0; b < 4; b++)
               if (ram_we[gi][b]) mem[ram_addr[gi][7:2]][b*8 +: 8] <= ram_wdata[gi][b*8 +: 8];
         pipe[0] <= ram_en[gi] ? mem[ram_addr[gi][7:2]] : 32'hA5A5_A5A5;
         for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
      end
      assign ram_rdata[gi] = pipe[L-1];
   end

   typedef struct {
      int          inst;
      int          port;
      logic [3:0]  w;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic run_txn(input vec_t v);
      int  lat;
      int  cyc;
      bit  seen;
      bit  other;
      lat = (v.inst == 2) ? 3 : 1;
      req[v.inst][v.port]   = 1'b1;
      we[v.inst][v.port]    = v.w;
      addr[v.inst][v.port]  = v.a;
      wdata[v.inst][v.port] = v.d;
      tick();
      chk("issue_en", 32'(ram_en[v.inst]), 32'd1);
      chk("issue_addr", ram_addr[v.inst], {v.a[31:2], 2'b00});
      chk("issue_we", 32'(ram_we[v.inst]), 32'(v.w));
      chk("grant", 32'(grant_id[v.inst]), 32'(v.port));
      if (v.w != 4'd0) chk("issue_wdata", ram_wdata[v.inst], v.d);
      cyc = 1; seen = 1'b0; other = 1'b0;
      while (!seen && cyc < 20) begin
         tick();
         cyc++;
         if (cyc == 2) chk("en_pulse", 32'(ram_en[v.inst]), 32'd0);
         if (ack[v.inst][1-v.port]) other = 1'b1;
         if (ack[v.inst][v.port]) seen = 1'b1;
      end
      req[v.inst][v.port] = 1'b0;
      chk("ack_seen", 32'(seen), 32'd1);
      chk("ack_cycle", 32'(cyc), 32'(2 + lat));
      chk("foreign_ack", 32'(other), 32'd0);
      chk("rdata", rdata[v.inst][v.port], v.exp_rd);
      $display("txn inst=%0d port=%0d we=%h addr=%h rdata=%h ack_cyc=%0d",
               v.inst, v.port, v.w, v.a, rdata[v.inst][v.port], cyc);
      tick();
      chk("ack_pulse", 32'(ack[v.inst][v.port]), 32'd0);
   endtask

   task automatic wait_ack(input int i, input int p, output bit seen, output bit other);
      int cyc;
      seen = 1'b0; other = 1'b0; cyc = 0;
      while (!seen && cyc < 20) begin
         tick();
         cyc++;
         if (ack[i][1-p]) other = 1'b1;
         if (ack[i][p]) seen = 1'b1;
      end
   endtask

   initial begin
      int  n, n0, n1, cyc;
      bit  both, seen, other;
      logic exp_g [4];

      for (int i = 0; i < 3; i++)
         for (int p = 0; p < 2; p++) begin
            req[i][p] = 1'b0; we[i][p] = 4'd0; addr[i][p] = 32'd0; wdata[i][p] = 32'd0;
         end
      rst = 1'b1;
      tick();
      do_reset();

      for (int i = 0; i < 3; i++) begin
         chk("rst_busy", 32'(busy[i]), 32'd0);
         chk("rst_en", 32'(ram_en[i]), 32'd0);
         chk("rst_we", 32'(ram_we[i]), 32'd0);
         chk("rst_grant", 32'(grant_id[i]), 32'd0);
         chk("rst_ack0", 32'(ack[i][0]), 32'd0);
         chk("rst_ack1", 32'(ack[i][1]), 32'd0);
         chk("rst_rdata0", rdata[i][0], 32'd0);
         chk("rst_rdata1", rdata[i][1], 32'd0);
      end

      vecs[0]  = '{0, 1, 4'hF, 32'h10, 32'hDEAD_BEEF, 32'h0};
      vecs[1]  = '{0, 0, 4'h0, 32'h13, 32'h0,         32'hDEAD_BEEF};
      vecs[2]  = '{0, 1, 4'hF, 32'h20, 32'h1122_3344, 32'h0};
      vecs[3]  = '{0, 1, 4'h0, 32'h20, 32'h0,         32'h1122_3344};
      vecs[4]  = '{0, 1, 4'h4, 32'h20, 32'h00AB_0000, 32'h1122_3344};
      vecs[5]  = '{0, 1, 4'h0, 32'h20, 32'h0,         32'h11AB_3344};
      vecs[6]  = '{0, 0, 4'h3, 32'h22, 32'h0000_5566, 32'hDEAD_BEEF};
      vecs[7]  = '{0, 0, 4'h0, 32'h21, 32'h0,         32'h11AB_5566};
      vecs[8]  = '{2, 1, 4'hF, 32'h40, 32'h1234_5678, 32'h0};
      vecs[9]  = '{2, 0, 4'h0, 32'h40, 32'h0,         32'h1234_5678};
      vecs[10] = '{1, 0, 4'hF, 32'h3C, 32'hCAFE_F00D, 32'h0};
      vecs[11] = '{1, 1, 4'h0, 32'h3C, 32'h0,         32'hCAFE_F00D};
      for (int k = 0; k < 12; k++) run_txn(vecs[k]);

      // Round-robin with both ports held: grants must alternate starting at port 0.
      do_reset();
      exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0; exp_g[3] = 1'b1;
      req[0][0] = 1'b1; we[0][0] = 4'd0; addr[0][0] = 32'h10;
      req[0][1] = 1'b1; we[0][1] = 4'd0; addr[0][1] = 32'h20;
      n = 0; cyc = 0; both = 1'b0;
      while (n < 4 && cyc < 60) begin
         tick();
         cyc++;
         if (ack[0][0] && ack[0][1]) both = 1'b1;
         if (ack[0][0] || ack[0][1]) begin
            chk("rr_grant", 32'(grant_id[0]), 32'(exp_g[n]));
            chk("rr_ack_port", 32'(ack[0][1]), 32'(exp_g[n]));
            $display("txn rr n=%0d grant=%0d ack0=%0d ack1=%0d", n, grant_id[0], ack[0][0], ack[0][1]);
            n++;
         end
      end
      req[0][0] = 1'b0; req[0][1] = 1'b0;
      chk("rr_count", 32'(n), 32'd4);
      chk("rr_both", 32'(both), 32'd0);
      for (int k = 0; k < 6; k++) tick();

      // Fixed priority: port 1 starves while port 0 keeps requesting.
      do_reset();
      req[1][0] = 1'b1; we[1][0] = 4'd0; addr[1][0] = 32'h3C;
      req[1][1] = 1'b1; we[1][1] = 4'd0; addr[1][1] = 32'h3C;
      n0 = 0; n1 = 0; cyc = 0;
      while ((n0 + n1) < 4 && cyc < 60) begin
         tick();
         cyc++;
         if (ack[1][0]) n0++;
         if (ack[1][1]) n1++;
         if (ack[1][0] || ack[1][1])
            $display("txn fixed ack0=%0d ack1=%0d grant=%0d", ack[1][0], ack[1][1], grant_id[1]);
      end
      req[1][0] = 1'b0; req[1][1] = 1'b0;
      chk("fp_m0_acks", 32'(n0), 32'd4);
      chk("fp_m1_acks", 32'(n1), 32'd0);
      for (int k = 0; k < 6; k++) tick();

      // Reset in the WAIT state of a read discards it entirely.
      do_reset();
      req[0][0] = 1'b1; we[0][0] = 4'd0; addr[0][0] = 32'h10;
      tick();
      tick();
      chk("abort_busy_before", 32'(busy[0]), 32'd1);
      rst = 1'b1;
      req[0][0] = 1'b0;
      tick();
      rst = 1'b0;
      chk("abort_busy", 32'(busy[0]), 32'd0);
      chk("abort_en", 32'(ram_en[0]), 32'd0);
      chk("abort_ack", 32'(ack[0][0]), 32'd0);
      chk("abort_rdata", rdata[0][0], 32'd0);
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (ack[0][0] || ack[0][1]) seen = 1'b1;
      end
      chk("abort_no_late_ack", 32'(seen), 32'd0);
      chk("abort_rdata_held", rdata[0][0], 32'd0);
      $display("txn abort busy=%0d rdata=%h", busy[0], rdata[0][0]);

      req[0][0] = 1'b1; we[0][0] = 4'd0; addr[0][0] = 32'h10;
      req[0][1] = 1'b1; we[0][1] = 4'd0; addr[0][1] = 32'h20;
      tick();
      chk("post_rst_grant", 32'(grant_id[0]), 32'd0);
      chk("post_rst_addr", ram_addr[0], 32'h10);
      wait_ack(0, 0, seen, other);
      req[0][0] = 1'b0;
      chk("post_rst_ack0", 32'(seen), 32'd1);
      chk("post_rst_foreign0", 32'(other), 32'd0);
      chk("post_rst_rdata0", rdata[0][0], 32'hDEAD_BEEF);
      $display("txn post_rst port=0 rdata=%h", rdata[0][0]);
      wait_ack(0, 1, seen, other);
      req[0][1] = 1'b0;
      chk("post_rst_ack1", 32'(seen), 32'd1);
      chk("post_rst_foreign1", 32'(other), 32'd0);
      chk("post_rst_rdata1", rdata[0][1], 32'h11AB_5566);
      $display("txn post_rst port=1 rdata=%h", rdata[0][1]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
